// File: rtl/alarm_input_conditioner_pkg.sv
// Shared constants and types for the alarm clock input conditioner.
// Default cycle counts assume a 50 MHz system clock.
package alarm_input_pkg;

  localparam int DEB_CYCLES_50MHZ    = 1_000_000;
  localparam int REPEAT_DELAY_50MHZ  = 25_000_000;
  localparam int REPEAT_PERIOD_50MHZ = 5_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_input_conditioner_debounce_channel.sv
// One input channel: two-flop synchronizer, debounce filter holding the
// accepted level, and a one-cycle pulse on each accepted 0->1 change.
module debounce_channel
  import alarm_input_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronized input agrees with the accepted level
  // restarts the count, so only an uninterrupted run can change the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        rise   <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_input_conditioner.sv
// Board key/switch front end for the alarm core: debounced switch levels,
// single press pulses for keys, and hold-to-repeat on UP and DOWN.
module alarm_input_conditioner
  import alarm_input_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_CYCLES_50MHZ,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_50MHZ,
  parameter int REPEAT_PERIOD  = REPEAT_PERIOD_50MHZ,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic key_set_raw,
  input  logic key_up_raw,
  input  logic key_down_raw,
  input  logic sw_sel_raw,
  input  logic sw_alarm_raw,
  output logic btn_set_export,
  output logic btn_up_export,
  output logic btn_down_export,
  output logic swc_sel_export,
  output logic swc_alarm_export
);

  localparam int TW_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW     = (TW_MAX > 1) ? $clog2(TW_MAX) : 1;
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  // Channel order: 0 set, 1 up, 2 down, 3 sel, 4 alarm; all pressed/on = 1.
  logic [4:0] raw_n;
  logic [4:0] stable;
  logic [4:0] rise;
  logic [1:0] rep_fire;
  logic       both_held;
  logic       unused_switch_rise;

  assign raw_n = {sw_alarm_raw, sw_sel_raw,
                  {key_down_raw, key_up_raw, key_set_raw} ^ {3{KEY_ACTIVE_LOW}}};
  assign both_held          = stable[1] & stable[2];
  assign unused_switch_rise = ^rise[4:3];

  for (genvar ch = 0; ch < 5; ch++) begin : g_channel
    debounce_channel #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .clk   (clk_clk),
      .reset (reset_reset),
      .raw   (raw_n[ch]),
      .stable(stable[ch]),
      .rise  (rise[ch])
    );
  end

  // Holding UP and DOWN together freezes both timers so neither value runs.
  for (genvar k = 0; k < 2; k++) begin : g_repeat
    repeat_state_t state;
    logic [TW-1:0] timer;

    assign rep_fire[k] = stable[k+1] & ~both_held &
                         (((state == DELAY)  && (timer == DELAY_LAST)) ||
                          ((state == REPEAT) && (timer == PERIOD_LAST)));

    always_ff @(posedge clk_clk) begin
      if (reset_reset || !stable[k+1]) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise[k+1]) begin
              state <= DELAY;
              timer <= '0;
            end
          end
          DELAY: begin
            if (!both_held) begin
              if (timer == DELAY_LAST) begin
                state <= REPEAT;
                timer <= '0;
              end else begin
                timer <= timer + TW'(1);
              end
            end
          end
          REPEAT: begin
            if (!both_held) begin
              timer <= (timer == PERIOD_LAST) ? '0 : timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      btn_set_export   <= 1'b0;
      btn_up_export    <= 1'b0;
      btn_down_export  <= 1'b0;
      swc_sel_export   <= 1'b0;
      swc_alarm_export <= 1'b0;
    end else begin
      btn_set_export   <= rise[0];
      btn_up_export    <= rise[1] | rep_fire[0];
      btn_down_export  <= rise[2] | rep_fire[1];
      swc_sel_export   <= stable[3];
      swc_alarm_export <= stable[4];
    end
  end

endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Scoreboard bench: directed scenarios plus random bouncing inputs, each
// edge predicted by a behavioural model and checked by a separate monitor.
module tb_alarm_input_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  localparam logic [4:0] SET  = 5'b00001;
  localparam logic [4:0] UP   = 5'b00010;
  localparam logic [4:0] DOWN = 5'b00100;
  localparam logic [4:0] SEL  = 5'b01000;
  localparam logic [4:0] ALM  = 5'b10000;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic key_set_raw = 1'b1;
  logic key_up_raw = 1'b1;
  logic key_down_raw = 1'b1;
  logic sw_sel_raw = 1'b0;
  logic sw_alarm_raw = 1'b0;
  logic btn_set_export;
  logic btn_up_export;
  logic btn_down_export;
  logic swc_sel_export;
  logic swc_alarm_export;

  // Pressed/on = 1 view of the inputs, bit order set, up, down, sel, alarm.
  logic [4:0] press = '0;

  logic [4:0] exp_q[$];
  logic [4:0] ywin[$];
  logic [4:0] m_level = '0;
  logic [4:0] m_rose = '0;
  logic [4:0] m_p1 = '0;
  logic [4:0] m_p2 = '0;
  logic [1:0] m_armed = '0;
  int         m_act[2];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cycle = 0;

  alarm_input_conditioner #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset     (reset_reset),
    .key_set_raw     (key_set_raw),
    .key_up_raw      (key_up_raw),
    .key_down_raw    (key_down_raw),
    .sw_sel_raw      (sw_sel_raw),
    .sw_alarm_raw    (sw_alarm_raw),
    .btn_set_export  (btn_set_export),
    .btn_up_export   (btn_up_export),
    .btn_down_export (btn_down_export),
    .swc_sel_export  (swc_sel_export),
    .swc_alarm_export(swc_alarm_export)
  );

  always #5 clk_clk = ~clk_clk;

  // Predicts the outputs just after the current edge: a level is accepted
  // once the last DEB synchronized samples all disagree with it; repeats
  // fire after RD, then every RP, edges of held time that is not frozen.
  task automatic model_edge(input logic rst);
    logic [4:0] l_prev, r_prev, y, expv;
    logic [1:0] btn;
    logic       both, fire, all_diff;
    if (rst) begin
      m_level = '0;
      m_rose  = '0;
      m_p1    = '0;
      m_p2    = '0;
      m_armed = '0;
      m_act[0] = 0;
      m_act[1] = 0;
      ywin.delete();
      expv = '0;
    end else begin
      l_prev = m_level;
      r_prev = m_rose;
      both   = l_prev[1] & l_prev[2];
      for (int k = 0; k < 2; k++) begin
        fire = 1'b0;
        if (!l_prev[k+1]) begin
          m_armed[k] = 1'b0;
        end else if (!m_armed[k]) begin
          if (r_prev[k+1]) begin
            m_armed[k] = 1'b1;
            m_act[k]   = 0;
          end
        end else if (!both) begin
          m_act[k]++;
          if (m_act[k] == RD || (m_act[k] > RD && (m_act[k] - RD) % RP == 0))
            fire = 1'b1;
        end
        btn[k] = r_prev[k+1] | fire;
      end
      expv = {r_prev[0], btn[0], btn[1], l_prev[3], l_prev[4]};
      y    = m_p2;
      m_p2 = m_p1;
      m_p1 = press;
      ywin.push_back(y);
      if (ywin.size() > DEB) void'(ywin.pop_front());
      m_rose = '0;
      for (int c = 0; c < 5; c++) begin
        all_diff = (ywin.size() == DEB);
        foreach (ywin[i]) if (ywin[i][c] == l_prev[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~l_prev[c];
          m_rose[c]  = ~l_prev[c];
        end
      end
    end
    exp_q.push_back(expv);
  endtask

  task automatic apply_stimulus(input logic [4:0] p, input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      press        = p;
      reset_reset  = rst;
      key_set_raw  = ~p[0];
      key_up_raw   = ~p[1];
      key_down_raw = ~p[2];
      sw_sel_raw   = p[3];
      sw_alarm_raw = p[4];
      @(posedge clk_clk);
      cycle++;
      model_edge(rst);
      #1;
    end
  endtask

  task automatic check_output(input logic [4:0] got, input logic [4:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL outputs{set,up,down,sel,alarm} cycle %0d: got %b expected %b",
               cycle, got, expv);
    end
  endtask

  initial begin : monitor
    logic [4:0] expv;
    forever begin
      @(negedge clk_clk);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        check_output({btn_set_export, btn_up_export, btn_down_export,
                      swc_sel_export, swc_alarm_export}, expv);
      end
    end
  end

  initial begin : driver
    logic [4:0] p;
    logic       rst;
    apply_stimulus('0, 1'b1, 3);
    apply_stimulus('0, 1'b0, 6);
    // Clean SET press: one pulse however long it is held.
    apply_stimulus(SET, 1'b0, 20);
    apply_stimulus('0, 1'b0, 12);
    // Bouncing UP settling into a long hold with auto-repeat.
    for (int i = 0; i < 6; i++) apply_stimulus((i % 2) ? 5'b0 : UP, 1'b0, 2);
    apply_stimulus(UP, 1'b0, 40);
    apply_stimulus('0, 1'b0, 12);
    // UP held, DOWN joins during the delay, then DOWN released.
    apply_stimulus(UP, 1'b0, 9);
    apply_stimulus(UP | DOWN, 1'b0, 25);
    apply_stimulus(UP, 1'b0, 30);
    apply_stimulus('0, 1'b0, 12);
    // Reset pulse while UP is repeating, key still held afterwards.
    apply_stimulus(UP, 1'b0, 30);
    apply_stimulus(UP, 1'b1, 1);
    apply_stimulus(UP, 1'b0, 30);
    apply_stimulus('0, 1'b0, 12);
    // Alarm switch on, short glitch off, then off; select toggles.
    apply_stimulus(ALM, 1'b0, 15);
    apply_stimulus('0, 1'b0, 3);
    apply_stimulus(ALM | SEL, 1'b0, 15);
    apply_stimulus(SEL, 1'b0, 15);
    apply_stimulus('0, 1'b0, 12);
    // Random: fast bouncing, then slow holds long enough to repeat.
    p = '0;
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 5; c++) if ($urandom_range(0, 3) == 0) p[c] = ~p[c];
      rst = ($urandom_range(0, 199) == 0);
      apply_stimulus(p, rst, 1);
    end
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 5; c++) if ($urandom_range(0, 39) == 0) p[c] = ~p[c];
      rst = ($urandom_range(0, 499) == 0);
      apply_stimulus(p, rst, 1);
    end
    apply_stimulus('0, 1'b0, 20);
    @(negedge clk_clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
